multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Control unit for the RV32I-subset datapath. It consumes the datapath's `instr` and `status` outputs and drives the datapath control inputs (pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl), which the testbench currently drives by hand. It is a multicycle FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, with a ready handshake to data memory. It adds the PC/IR write strobes the datapath needs to run multicycle.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for mem_ready before a bus-error halt (range 1..255)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
instr  input  32  current instruction word from datapath instruction memory
status  input  5  ALU flags; [0]=Z, [1]=N, [2]=C, [3]=V, [4] reserved/ignored
mem_ready  input  1  data memory completion, sampled only in MEM
pcsrc  output  1  PC mux: 0 = PC+4, 1 = PC+imm (branch target)
alusrc  output  1  ALU B mux: 0 = rs2, 1 = immediate
aluop  output  4  0010 add, 0110 sub, 0000 and, 0001 or
memrw  output  1  data memory: 1 = write, 0 = read
wb  output  1  write-back mux: 0 = ALU result, 1 = memory data
regrw  output  1  register file write enable
immgen_ctrl  output  2  00 I-ALU, 01 I-load, 10 S-type, 11 B-type
pc_we  output  1  PC register write strobe
ir_we  output  1  instruction register write strobe
halted  output  1  sticky halt flag (illegal instruction or memory timeout)

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- Reset (rst=0 at a clock edge): next state is FETCH. The timeout counter clears and halted clears. Reset in any state, including MEM mid-access and HALT, aborts with no further strobes.
- Output defaults in every state: all strobes/enables 0, pcsrc 0, alusrc 0, aluop 0010, memrw 0, wb 0, immgen_ctrl 00. All outputs hold these values during the reset cycle.
- Outputs are combinational from the current state and the latched fields. They are glitch-tolerant only; the datapath samples them on clk.
- FETCH: ir_we=1. The controller latches opcode[6:0], funct3[14:12] and funct7[30] from instr. Next state is DECODE.
- DECODE: immgen_ctrl is driven per opcode. Next state is EXEC if the instruction is legal, otherwise HALT.
- Legal instructions:
  - R-type 0110011: add (f3=000, f7b=0), sub (000, 1), and (111, 0), or (110, 0).
  - I-ALU 0010011: addi (f3=000).
  - Load 0000011: lw (f3=010).
  - Store 0100011: sw (f3=010).
  - Branch 1100011: beq (f3=000).
  - Anything else is illegal.
- EXEC:
  - R-type: alusrc=0, aluop per funct. Next state is WB.
  - addi: alusrc=1, aluop=0010, immgen 00. Next state is WB.
  - lw/sw: alusrc=1, aluop=0010, immgen 01/10. Next state is MEM.
  - beq: alusrc=0, aluop=0110, immgen 11, pc_we=1, pcsrc=status[0]. Next state is FETCH.
- MEM: alusrc=1, aluop=0010 are held; memrw=1 for sw, 0 for lw.
  - If mem_ready=1: lw goes to WB; sw asserts pc_we=1 in this cycle and goes to FETCH.
  - If mem_ready=0: stay and increment the wait counter.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready still 0: go to HALT.
- Store write: the sw memory write occurs only in the cycle mem_ready=1 is seen. memrw stays high while waiting; memory must not commit twice.
- WB: regrw=1, pc_we=1. wb=1 for lw, 0 otherwise. The aluop/alusrc values of EXEC are held so the result is stable. Next state is FETCH.
- Latency in cycles, instruction start to next FETCH:
  - beq: 3
  - R/addi: 4
  - sw: 4 + wait cycles
  - lw: 5 + wait cycles
- HALT: halted=1, all strobes 0. Held until reset.
- status is sampled only in EXEC of beq. mem_ready is ignored outside MEM.

Optional Feature:
CTRL_INSTRET_EN. When defined, adds output port instret (32 bits), a retired-instruction counter.
- Reset value 0.
- Increments by 1 on each cycle in which pc_we=1.
- Wraps from 0xFFFFFFFF to 0.
- Does not count in HALT.

When not defined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3), mem_ready=0 -> ir_we in cycle 1; WB in cycle 4 with regrw=1, wb=0, aluop=0010, alusrc=0, pc_we=1.
- beq with status=5'b00001 -> EXEC shows pcsrc=1, pc_we=1, aluop=0110, immgen_ctrl=11; 3 cycles total. Repeat with status=0 -> pcsrc=0.
- lw (0x0000A183) with mem_ready held 0 for 3 cycles then 1 -> MEM held 4 cycles with memrw=0; then WB with wb=1, regrw=1; 8 cycles total.
- sw (0x0030A023) with MEM_TIMEOUT=4 and mem_ready never 1 -> halted=1 after 4 MEM cycles, no pc_we, regrw=0. Then rst=0 for one edge -> FETCH, halted=0.
- Illegal opcode 0x0000007F -> DECODE to HALT with no regrw/memrw/pc_we ever asserted. Also reset asserted mid-MEM -> next cycle FETCH with all strobes 0.
- With CTRL_INSTRET_EN: sequence add, beq, lw, sw -> instret=4. Then illegal -> stays 4.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle FSM control unit for the RV32I-subset datapath.
//            Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath mux/ALU
//            controls and the PC/IR write strobes, and halts on illegal
//            instructions or a data-memory timeout.
//            Optional macro CTRL_INSTRET_EN adds a 32-bit retired-instruction
//            counter output (instret).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [4:0]  status,
    input  logic        mem_ready,
    output logic        pcsrc,
    output logic        alusrc,
    output logic [3:0]  aluop,
    output logic        memrw,
    output logic        wb,
    output logic        regrw,
    output logic [1:0]  immgen_ctrl,
    output logic        pc_we,
    output logic        ir_we,
    output logic        halted
`ifdef CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    // FSM state encoding
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    // Opcodes of the supported subset
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;

    // Decoded instruction classes
    localparam logic [3:0] c_CL_ILLEGAL = 4'd0;
    localparam logic [3:0] c_CL_ADD     = 4'd1;
    localparam logic [3:0] c_CL_SUB     = 4'd2;
    localparam logic [3:0] c_CL_AND     = 4'd3;
    localparam logic [3:0] c_CL_OR      = 4'd4;
    localparam logic [3:0] c_CL_ADDI    = 4'd5;
    localparam logic [3:0] c_CL_LW      = 4'd6;
    localparam logic [3:0] c_CL_SW      = 4'd7;
    localparam logic [3:0] c_CL_BEQ     = 4'd8;

    // Last wait-counter value tolerated in MEM before giving up
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [6:0] r_opcode;
    logic [2:0] r_funct3;
    logic       r_funct7b;
    logic [7:0] r_wait_cnt;
    logic [3:0] w_cls;
    logic [1:0] w_imm;
    logic [3:0] w_alu_op;
    logic       w_alu_src;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_timeout;
    logic       w_unused;

    // Instruction bits the controller never looks at, plus the reserved flags
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7], status[4:1]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the decode fields while the instruction is being fetched
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_opcode  <= 7'd0;
            r_funct3  <= 3'd0;
            r_funct7b <= 1'b0;
        end else if (r_state == c_ST_FETCH) begin
            r_opcode  <= instr[6:0];
            r_funct3  <= instr[14:12];
            r_funct7b <= instr[30];
        end
    end

    // Count cycles spent waiting on data memory; restarts on every MEM entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
        end else if ((r_state == c_ST_MEM) && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    assign w_timeout = (r_wait_cnt == c_TIMEOUT_LAST);

    // Classify the latched instruction; anything unlisted is illegal
    always_comb begin
        w_cls = c_CL_ILLEGAL;
        case (r_opcode)
            c_OP_RTYPE: begin
                if      ((r_funct3 == 3'b000) && !r_funct7b) w_cls = c_CL_ADD;
                else if ((r_funct3 == 3'b000) &&  r_funct7b) w_cls = c_CL_SUB;
                else if ((r_funct3 == 3'b111) && !r_funct7b) w_cls = c_CL_AND;
                else if ((r_funct3 == 3'b110) && !r_funct7b) w_cls = c_CL_OR;
                else                                         w_cls = c_CL_ILLEGAL;
            end
            c_OP_IALU:   if (r_funct3 == 3'b000) w_cls = c_CL_ADDI;
            c_OP_LOAD:   if (r_funct3 == 3'b010) w_cls = c_CL_LW;
            c_OP_STORE:  if (r_funct3 == 3'b010) w_cls = c_CL_SW;
            c_OP_BRANCH: if (r_funct3 == 3'b000) w_cls = c_CL_BEQ;
            default:     w_cls = c_CL_ILLEGAL;
        endcase
    end

    // Immediate format follows the opcode alone
    always_comb begin
        w_imm = 2'b00;
        case (r_opcode)
            c_OP_LOAD:   w_imm = 2'b01;
            c_OP_STORE:  w_imm = 2'b10;
            c_OP_BRANCH: w_imm = 2'b11;
            default:     w_imm = 2'b00;
        endcase
    end

    // ALU operation and B-operand source for the decoded class
    always_comb begin
        w_alu_op  = c_ALU_ADD;
        w_alu_src = 1'b0;
        case (w_cls)
            c_CL_SUB:  w_alu_op = c_ALU_SUB;
            c_CL_BEQ:  w_alu_op = c_ALU_SUB;
            c_CL_AND:  w_alu_op = c_ALU_AND;
            c_CL_OR:   w_alu_op = c_ALU_OR;
            c_CL_ADDI: w_alu_src = 1'b1;
            c_CL_LW:   w_alu_src = 1'b1;
            c_CL_SW:   w_alu_src = 1'b1;
            default:   w_alu_op = c_ALU_ADD;
        endcase
    end

    assign w_is_lw = (w_cls == c_CL_LW);
    assign w_is_sw = (w_cls == c_CL_SW);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_FETCH:  w_next = c_ST_DECODE;
            c_ST_DECODE: w_next = (w_cls == c_CL_ILLEGAL) ? c_ST_HALT : c_ST_EXEC;
            c_ST_EXEC: begin
                case (w_cls)
                    c_CL_BEQ:     w_next = c_ST_FETCH;
                    c_CL_LW:      w_next = c_ST_MEM;
                    c_CL_SW:      w_next = c_ST_MEM;
                    c_CL_ILLEGAL: w_next = c_ST_HALT;
                    default:      w_next = c_ST_WB;
                endcase
            end
            c_ST_MEM: begin
                if (mem_ready)      w_next = w_is_lw ? c_ST_WB : c_ST_FETCH;
                else if (w_timeout) w_next = c_ST_HALT;
                else                w_next = c_ST_MEM;
            end
            c_ST_WB:     w_next = c_ST_FETCH;
            c_ST_HALT:   w_next = c_ST_HALT;
            default:     w_next = c_ST_HALT;
        endcase
    end

    // Output decode; everything is forced to its idle value while in reset
    always_comb begin
        pcsrc       = 1'b0;
        alusrc      = 1'b0;
        aluop       = c_ALU_ADD;
        memrw       = 1'b0;
        wb          = 1'b0;
        regrw       = 1'b0;
        immgen_ctrl = 2'b00;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            case (r_state)
                c_ST_FETCH: ir_we = 1'b1;
                c_ST_DECODE: immgen_ctrl = w_imm;
                c_ST_EXEC: begin
                    alusrc      = w_alu_src;
                    aluop       = w_alu_op;
                    immgen_ctrl = w_imm;
                    if (w_cls == c_CL_BEQ) begin
                        pc_we = 1'b1;
                        pcsrc = status[0];
                    end
                end
                c_ST_MEM: begin
                    // Address inputs stay stable for the whole access; a store
                    // only retires (pc_we) in the cycle memory accepts it
                    alusrc      = 1'b1;
                    aluop       = c_ALU_ADD;
                    immgen_ctrl = w_imm;
                    memrw       = w_is_sw;
                    pc_we       = w_is_sw && mem_ready;
                end
                c_ST_WB: begin
                    alusrc      = w_alu_src;
                    aluop       = w_alu_op;
                    immgen_ctrl = w_imm;
                    regrw       = 1'b1;
                    pc_we       = 1'b1;
                    wb          = w_is_lw;
                end
                c_ST_HALT: halted = 1'b1;
                default:   halted = 1'b0;
            endcase
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [31:0] r_instret;

    // Each PC write retires exactly one instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instret <= 32'd0;
        end else if (pc_we) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule
`default_nettype wire
